// File: rtl/data_mem_responder.sv
// Handshaked word-organised data memory: one load/store in flight, fixed wait states,
// one registered response (data, completion or error) per accepted request.
module data_mem_responder #(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned WAIT_CYCLES = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [31:0]       req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [3:0]        req_be,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err
);

   localparam int unsigned Depth = 2 ** ADDR_W;

   typedef enum logic [1:0] {StIdle, StWait, StResp} stateE;

   stateE              stateQ, stateD;
   logic [3:0]         cntQ, cntD;
   logic               latWriteQ;
   logic [31:0]        latAddrQ;
   logic [DATA_W-1:0]  latWdataQ;
   logic [3:0]         latBeQ;
   logic               reqReadyQ, reqReadyD;
   logic               respValidQ, respValidD;
   logic               respErrQ, respErrD;
   logic [DATA_W-1:0]  respRdataQ, respRdataD;
   logic               accept, commit, addrErr;
   logic [ADDR_W-1:0]  wordIdx;
   logic [DATA_W-1:0]  mem [Depth];

   assign accept  = (stateQ == StIdle) && req_valid && reqReadyQ;
   // Counter runs down to zero so the response lands WAIT_CYCLES+1 edges after accept.
   assign commit  = (stateQ == StWait) && (cntQ == 4'd0);
   assign wordIdx = latAddrQ[ADDR_W+1:2];
   assign addrErr = (latAddrQ[1:0] != 2'b00) || (latAddrQ[31:ADDR_W+2] != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateQ     <= StIdle;
         cntQ       <= 4'd0;
         latWriteQ  <= 1'b0;
         latAddrQ   <= '0;
         latWdataQ  <= '0;
         latBeQ     <= 4'h0;
         reqReadyQ  <= 1'b1;
         respValidQ <= 1'b0;
         respErrQ   <= 1'b0;
         respRdataQ <= '0;
      end else begin
         stateQ     <= stateD;
         cntQ       <= cntD;
         reqReadyQ  <= reqReadyD;
         respValidQ <= respValidD;
         respErrQ   <= respErrD;
         respRdataQ <= respRdataD;
         if (accept) begin
            latWriteQ <= req_write;
            latAddrQ  <= req_addr;
            latWdataQ <= req_wdata;
            latBeQ    <= req_be;
         end
      end
   end

   always_comb begin
      stateD = stateQ;
      cntD   = cntQ;
      unique case (stateQ)
         StIdle: begin
            if (accept) begin
               stateD = StWait;
               cntD   = 4'(WAIT_CYCLES);
            end
         end
         StWait: begin
            if (cntQ == 4'd0) stateD = StResp;
            else              cntD   = cntQ - 4'd1;
         end
         StResp: begin
            if (resp_ready) stateD = StIdle;
         end
         default: stateD = StIdle;
      endcase
   end

   always_comb begin
      reqReadyD  = (stateD == StIdle);
      respValidD = (stateD == StResp);
      respErrD   = respErrQ;
      respRdataD = respRdataQ;
      if (commit) begin
         respErrD   = addrErr;
         respRdataD = (addrErr || latWriteQ) ? '0 : mem[wordIdx];
      end else if ((stateQ == StResp) && resp_ready) begin
         respErrD   = 1'b0;
         respRdataD = '0;
      end
   end

   // Contents are deliberately not reset; reset forces StIdle so no commit can occur.
   always_ff @(posedge clk) begin
      if (commit && latWriteQ && !addrErr) begin
         for (int i = 0; i < 4; i++) begin
            if (latBeQ[i]) mem[wordIdx][8*i +: 8] <= latWdataQ[8*i +: 8];
         end
      end
   end

   assign req_ready  = reqReadyQ;
   assign resp_valid = respValidQ;
   assign resp_err   = respErrQ;
   assign resp_rdata = respRdataQ;

endmodule

// File: tb/tb_data_mem_responder.sv
// Table-driven bench with a response scoreboard for data_mem_responder.
module tb_data_mem_responder;

   localparam int unsigned Wait = 3;

   logic        clk, rst_n;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_be;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] expRdata;
      logic        expErr;
   } vecT;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } expT;

   vecT vecs[14];
   expT expQ[$];
   int  checks = 0;
   int  errors = 0;

   data_mem_responder #(
      .ADDR_W      (10),
      .DATA_W      (32),
      .WAIT_CYCLES (Wait)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_be     (req_be),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   // Presents a request once req_ready is seen and drops it right after the accept edge.
   task automatic drive(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be);
      int n = 0;
      @(negedge clk);
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) check("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wdata;
      req_be    = be;
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic waitResp(output int edges);
      edges = 0;
      while (!resp_valid && edges < 40) begin
         @(posedge clk);
         #1 edges++;
      end
   endtask

   task automatic runReq(input string name, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic [31:0] expR, input logic expE);
      int  edges;
      expT e;
      expQ.push_back('{rdata: expR, err: expE});
      drive(wr, addr, wdata, be);
      waitResp(edges);
      check({name, "_latency"}, 32'(edges), 32'(Wait + 1));
      e = expQ.pop_front();
      if (!resp_valid) return;
      check({name, "_rdata"}, resp_rdata, e.rdata);
      check({name, "_err"}, 32'(resp_err), 32'(e.err));
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      check({name, "_valid_drop"}, 32'(resp_valid), 32'd0);
      check({name, "_ready_back"}, 32'(req_ready), 32'd1);
      check({name, "_rdata_clr"}, resp_rdata, 32'd0);
   endtask

   initial begin
      int  edges;
      logic quiet;
      clk = 1'b0; rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
      req_addr = '0; req_wdata = '0; req_be = '0; resp_ready = 1'b0;

      vecs[0]  = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0};
      vecs[1]  = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
      vecs[2]  = '{1'b1, 32'h0000_0040, 32'h1122_3344, 4'h5, 32'h0, 1'b0};
      vecs[3]  = '{1'b0, 32'h0000_0040, 32'h0,         4'hF, 32'hDE22_BE44, 1'b0};
      vecs[4]  = '{1'b0, 32'h0000_0042, 32'h0,         4'h0, 32'h0, 1'b1};
      vecs[5]  = '{1'b1, 32'h0000_0043, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1};
      vecs[6]  = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 32'hDE22_BE44, 1'b0};
      vecs[7]  = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, 32'h0, 1'b1};
      vecs[8]  = '{1'b1, 32'h0000_0FFC, 32'h0BAD_CAFE, 4'hF, 32'h0, 1'b0};
      vecs[9]  = '{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 32'h0BAD_CAFE, 1'b0};
      vecs[10] = '{1'b1, 32'h0000_0044, 32'h1234_5678, 4'hF, 32'h0, 1'b0};
      vecs[11] = '{1'b1, 32'h0000_0044, 32'hAABB_CCDD, 4'hA, 32'h0, 1'b0};
      vecs[12] = '{1'b0, 32'h0000_0044, 32'h0,         4'h0, 32'hAA34_CC78, 1'b0};
      vecs[13] = '{1'b0, 32'h8000_0040, 32'h0,         4'h0, 32'h0, 1'b1};

      #12;
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_resp_err", 32'(resp_err), 32'd0);
      @(negedge clk) rst_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         runReq($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                vecs[i].expRdata, vecs[i].expErr);
      end

      // Stalled response while a conflicting store is held on the request channel.
      drive(1'b0, 32'h40, 32'h0, 4'h0);
      waitResp(edges);
      check("stall_latency", 32'(edges), 32'(Wait + 1));
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_wdata = 32'h0; req_be = 4'hF;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         check("stall_valid", 32'(resp_valid), 32'd1);
         check("stall_rdata", resp_rdata, 32'hDE22_BE44);
         check("stall_err", 32'(resp_err), 32'd0);
         check("stall_req_ready", 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      req_valid = 1'b0;
      check("stall_release_ready", 32'(req_ready), 32'd1);
      check("stall_release_valid", 32'(resp_valid), 32'd0);
      runReq("stall_no_accept", 1'b0, 32'h40, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0);

      // Reset during the wait phase of a store aborts it.
      drive(1'b1, 32'h40, 32'hCAFE_F00D, 4'hF);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_req_ready", 32'(req_ready), 32'd1);
      check("abort_resp_valid", 32'(resp_valid), 32'd0);
      check("abort_resp_rdata", resp_rdata, 32'd0);
      check("abort_resp_err", 32'(resp_err), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      quiet = 1'b1;
      repeat (8) begin
         @(posedge clk);
         #1 if (resp_valid) quiet = 1'b0;
      end
      check("abort_no_resp", 32'(quiet), 32'd1);
      runReq("abort_mem_kept", 1'b0, 32'h40, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0);

      check("scoreboard_empty", 32'(expQ.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
